// File: rtl/sram_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM SRAM arbiter.
// Holds FSM state encodings, grant codes and default phase timing.
package sram_mem_arbiter_pkg;

    // Word transaction sequence: arbitrate, low half, high half, handshake.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    localparam int unsigned ACC_CYCLES_DEF = 2;

    // Wide enough for the largest legal phase length (15).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_mem_arbiter_phase_counter.sv
// Loadable down-counter timing one 16-bit SRAM phase.
// Ports: clk, rst (sync, active-high), load_i (restart phase),
//        phase_first_o (first phase cycle), phase_last_o (last phase cycle).
module sram_mem_arbiter_phase_counter
    import sram_mem_arbiter_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic phase_first_o,
    output logic phase_last_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACC_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load_i is raised the cycle before a phase starts, so the first
    // phase cycle always sees the full count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_first_o = (cnt_q == LOAD_VAL);
    assign phase_last_o  = (cnt_q == '0);

endmodule

// File: rtl/sram_mem_arbiter.sv
// Shares one 16-bit SRAM between the IF (read) and MEM (read/write) ports.
// Ports: clk/rst (sync, active-high); if_* and mem_* requester handshakes
//        (req held until one-cycle ready); busy; sram_* pad-side signals.
module sram_mem_arbiter
    import sram_mem_arbiter_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF,
    parameter int unsigned AW         = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_rdata,
    output logic          mem_ready,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    output logic [15:0]   sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_in,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          sram_ce_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    arb_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-2:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic cnt_load;
    logic phase_first;
    logic phase_last;
    logic in_phase;
    logic hi_phase;

    sram_mem_arbiter_phase_counter #(
        .ACC_CYCLES(ACC_CYCLES)
    ) u_phase_cnt (
        .clk          (clk),
        .rst          (rst),
        .load_i       (cnt_load),
        .phase_first_o(phase_first),
        .phase_last_o (phase_last)
    );

    assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);
    assign hi_phase = (state_q == ST_HI);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        cnt_load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    // On contention, serve whoever did not win last time.
                    if (if_req && mem_req) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = mem_req ? GRANT_MEM : GRANT_IF;
                    end
                    last_grant_d = grant_d;
                    if (grant_d == GRANT_MEM) begin
                        we_d    = mem_we;
                        waddr_d = mem_addr[AW:2];
                    end else begin
                        we_d    = 1'b0;
                        waddr_d = if_addr[AW:2];
                    end
                    wdata_d  = mem_wdata;
                    cnt_load = 1'b1;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    cnt_load = 1'b1;
                    state_d  = ST_HI;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read halves land on the last cycle of each phase, giving the
    // SRAM the full phase for its access time.
    always_comb begin
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if (in_phase && !we_q && phase_last) begin
            if (grant_q == GRANT_MEM) begin
                if (hi_phase) begin
                    mem_rdata_d[31:16] = sram_dq_in;
                end else begin
                    mem_rdata_d[15:0] = sram_dq_in;
                end
            end else begin
                if (hi_phase) begin
                    if_rdata_d[31:16] = sram_dq_in;
                end else begin
                    if_rdata_d[15:0] = sram_dq_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_IF;
            last_grant_q <= GRANT_IF;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign sram_addr   = in_phase ? {waddr_q, hi_phase} : '0;
    assign sram_ce_n   = ~in_phase;
    assign sram_oe_n   = ~(in_phase && !we_q);
    assign sram_dq_oe  = in_phase && we_q;
    assign sram_dq_out = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
    // Strobe held off on the first phase cycle for address setup.
    assign sram_we_n   = ~(in_phase && we_q && !phase_first);
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;

    assign if_ready  = (state_q == ST_DONE) && (grant_q == GRANT_IF);
    assign mem_ready = (state_q == ST_DONE) && (grant_q == GRANT_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != ST_IDLE);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:AW+1], if_addr[1:0],
                                mem_addr[31:AW+1], mem_addr[1:0]};

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Bench for sram_mem_arbiter: two instances (2- and 4-cycle phases),
// each with its own behavioural SRAM, driven by vectors and random traffic.
module tb_sram_mem_arbiter;

    localparam int A0 = 2;
    localparam int A1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel4;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;

    logic        if_req_w    [2];
    logic        mem_req_w   [2];
    logic [31:0] if_rdata_w  [2];
    logic [31:0] mem_rdata_w [2];
    logic        if_ready_w  [2];
    logic        mem_ready_w [2];
    logic        busy_w      [2];
    logic [17:0] sa_w        [2];
    logic [15:0] dq_out_w    [2];
    logic        dq_oe_w     [2];
    logic [15:0] dq_in_w     [2];
    logic        we_n_w      [2];
    logic        oe_n_w      [2];
    logic        ce_n_w      [2];
    logic        ub_n_w      [2];
    logic        lb_n_w      [2];

    assign if_req_w[0]  = if_req & ~sel4;
    assign if_req_w[1]  = if_req & sel4;
    assign mem_req_w[0] = mem_req & ~sel4;
    assign mem_req_w[1] = mem_req & sel4;

    sram_mem_arbiter #(.ACC_CYCLES(A0), .AW(18)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req_w[0]), .if_addr(if_addr),
        .if_rdata(if_rdata_w[0]), .if_ready(if_ready_w[0]),
        .mem_req(mem_req_w[0]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_w[0]),
        .mem_ready(mem_ready_w[0]), .busy(busy_w[0]),
        .sram_addr(sa_w[0]), .sram_dq_out(dq_out_w[0]),
        .sram_dq_oe(dq_oe_w[0]), .sram_dq_in(dq_in_w[0]),
        .sram_we_n(we_n_w[0]), .sram_oe_n(oe_n_w[0]),
        .sram_ce_n(ce_n_w[0]), .sram_ub_n(ub_n_w[0]), .sram_lb_n(lb_n_w[0])
    );

    sram_mem_arbiter #(.ACC_CYCLES(A1), .AW(18)) dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req_w[1]), .if_addr(if_addr),
        .if_rdata(if_rdata_w[1]), .if_ready(if_ready_w[1]),
        .mem_req(mem_req_w[1]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_w[1]),
        .mem_ready(mem_ready_w[1]), .busy(busy_w[1]),
        .sram_addr(sa_w[1]), .sram_dq_out(dq_out_w[1]),
        .sram_dq_oe(dq_oe_w[1]), .sram_dq_in(dq_in_w[1]),
        .sram_we_n(we_n_w[1]), .sram_oe_n(oe_n_w[1]),
        .sram_ce_n(ce_n_w[1]), .sram_ub_n(ub_n_w[1]), .sram_lb_n(lb_n_w[1])
    );

    // Behavioural SRAMs plus a backdoor for preloading.
    logic [15:0] sram [2][262144];
    logic        bd_we;
    logic        bd_sel;
    logic [17:0] bd_addr;
    logic [15:0] bd_data;

    assign dq_in_w[0] = sram[0][sa_w[0]];
    assign dq_in_w[1] = sram[1][sa_w[1]];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ce_n_w[k] && !we_n_w[k] && dq_oe_w[k])
                sram[k][sa_w[k]] <= dq_out_w[k];
        end
        if (bd_we)
            sram[bd_sel][bd_addr] <= bd_data;
    end

    logic        if_ready_s, mem_ready_s, busy_s;
    logic        we_n_s, oe_n_s, ce_n_s, dq_oe_s;
    logic [17:0] sa_s;
    logic [31:0] if_rdata_s, mem_rdata_s;
    assign if_ready_s  = if_ready_w[sel4];
    assign mem_ready_s = mem_ready_w[sel4];
    assign busy_s      = busy_w[sel4];
    assign we_n_s      = we_n_w[sel4];
    assign oe_n_s      = oe_n_w[sel4];
    assign ce_n_s      = ce_n_w[sel4];
    assign dq_oe_s     = dq_oe_w[sel4];
    assign sa_s        = sa_w[sel4];
    assign if_rdata_s  = if_rdata_w[sel4];
    assign mem_rdata_s = mem_rdata_w[sel4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic s, input logic [17:0] a,
                            input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_sel = s; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One single-port transaction; latency is counted in cycles from
    // the arbitration cycle, strobes are tallied per phase.
    task automatic run_one(input logic s4, input logic is_mem,
                           input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output int lat, output int wl0, output int wl1,
                           output int ol, output int orr);
        sel4 = s4;
        lat = 0; wl0 = 0; wl1 = 0; ol = 0; orr = 0; rd = '0;
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (!we_n_s) begin
                if (sa_s[0]) wl1++;
                else wl0++;
            end
            if (!oe_n_s) ol++;
            if (is_mem ? if_ready_s : mem_ready_s) orr++;
            if (is_mem ? mem_ready_s : if_ready_s) begin
                rd = is_mem ? mem_rdata_s : if_rdata_s;
                break;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    // Word-level reference: memory image, last grant, per-port rdata.
    logic [31:0] ref_mem [16];
    logic        lg_m;
    logic [31:0] exp_if_m, exp_mem_m;

    task automatic rnd_test(input int n);
        for (int it = 0; it < n; it++) begin
            int          mode, n_ev, step, cyc, both;
            logic [3:0]  iidx, midx;
            logic [31:0] r, iaddr, maddr, mwd;
            logic        mw, ig, mg, p;
            logic        ord [2];
            logic [31:0] ev  [2];
            mode = int'($urandom_range(2, 0));
            iidx = 4'($urandom);
            midx = 4'($urandom);
            r = $urandom;
            iaddr = {r[31:19], 13'd0, iidx, r[1:0]};
            r = $urandom;
            maddr = {r[31:19], 13'd0, midx, r[1:0]};
            mwd = $urandom;
            mw = 1'($urandom);
            ig = (mode != 1);
            mg = (mode != 0);
            if (ig && mg) begin
                ord[0] = (lg_m == 1'b0);
                ord[1] = ~ord[0];
                n_ev = 2;
            end else begin
                ord[0] = mg;
                ord[1] = ~mg;
                n_ev = 1;
            end
            for (int s = 0; s < n_ev; s++) begin
                if (ord[s]) begin
                    if (mw) ref_mem[midx] = mwd;
                    else exp_mem_m = ref_mem[midx];
                    ev[s] = exp_mem_m;
                end else begin
                    exp_if_m = ref_mem[iidx];
                    ev[s] = exp_if_m;
                end
            end
            lg_m = ord[n_ev-1];
            @(negedge clk);
            if_req = ig; if_addr = iaddr;
            mem_req = mg; mem_we = mw; mem_addr = maddr; mem_wdata = mwd;
            step = 0; cyc = 0; both = 0;
            while (step < n_ev && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (if_ready_s && mem_ready_s) both++;
                if (if_ready_s || mem_ready_s) begin
                    p = mem_ready_s;
                    chk("rnd_port", 32'(p), 32'(ord[step]));
                    chk("rnd_data", p ? mem_rdata_s : if_rdata_s, ev[step]);
                    chk("rnd_cycle", cyc, 5 + 6 * step);
                    if (p) mem_req = 1'b0;
                    else if_req = 1'b0;
                    step++;
                end
            end
            chk("rnd_done", step, n_ev);
            chk("rnd_both", both, 0);
            if_req = 1'b0; mem_req = 1'b0;
        end
    endtask

    typedef struct {
        logic        s4;
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] rd;
    int          lat, wl0, wl1, ol, orr, a;
    int          cyc, nrd, both, rdy, b0;
    logic        got  [4];
    int          gcyc [4];
    logic [31:0] gdat [4];
    logic [31:0] fexp [4];

    initial begin
        rst = 1'b1; sel4 = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        bd_we = 1'b0; bd_sel = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",   32'(busy_w[k]),      32'd0);
            chk("rst_if_rdy", 32'(if_ready_w[k]),  32'd0);
            chk("rst_mem_rdy",32'(mem_ready_w[k]), 32'd0);
            chk("rst_if_rd",  if_rdata_w[k],       32'd0);
            chk("rst_mem_rd", mem_rdata_w[k],      32'd0);
            chk("rst_ce_n",   32'(ce_n_w[k]),      32'd1);
            chk("rst_oe_n",   32'(oe_n_w[k]),      32'd1);
            chk("rst_we_n",   32'(we_n_w[k]),      32'd1);
            chk("rst_dq_oe",  32'(dq_oe_w[k]),     32'd0);
            chk("rst_addr",   32'(sa_w[k]),        32'd0);
            chk("rst_ub_lb",  32'({ub_n_w[k], lb_n_w[k]}), 32'd0);
        end
        rst = 1'b0;

        bd_write(1'b0, 18'h4, 16'hBEEF);
        bd_write(1'b0, 18'h5, 16'hDEAD);

        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0,
                   32'hDEAD_BEEF, 5};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678,
                   32'h0, 5};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,
                   32'h1234_5678, 5};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,
                   32'h1234_5678, 5};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF3, 32'hA5A5_5A5A,
                   32'h1234_5678, 5};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0007_FFF1, 32'h0,
                   32'hA5A5_5A5A, 5};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D,
                   32'h0, 9};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0,
                   32'hCAFE_F00D, 9};

        for (int i = 0; i < 8; i++) begin
            run_one(tbl[i].s4, tbl[i].is_mem, tbl[i].we, tbl[i].addr,
                    tbl[i].wd, rd, lat, wl0, wl1, ol, orr);
            a = tbl[i].s4 ? A1 : A0;
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_we_lo", i), wl0, tbl[i].we ? a - 1 : 0);
            chk($sformatf("vec%0d_we_hi", i), wl1, tbl[i].we ? a - 1 : 0);
            chk($sformatf("vec%0d_oe", i), ol, tbl[i].we ? 0 : 2 * a);
            chk($sformatf("vec%0d_other_rdy", i), orr, 0);
        end
        chk("sram_lo_half", 32'(sram[0][18'h8]), 32'h5678);
        chk("sram_hi_half", 32'(sram[0][18'h9]), 32'h1234);
        chk("sram4_lo_half", 32'(sram[1][18'h10]), 32'hF00D);

        // Reset in the middle of a low phase.
        sel4 = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy_pre", 32'(busy_s), 32'd1);
        rst = 1'b1; rdy = 0; b0 = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if_ready_s || mem_ready_s) rdy++;
            if (c == 0) b0 = int'(busy_s);
            if_req = 1'b0;
        end
        chk("rst_mid_busy_next", b0, 0);
        chk("rst_mid_ce_n", 32'(ce_n_s), 32'd1);
        chk("rst_mid_oe_n", 32'(oe_n_s), 32'd1);
        chk("rst_mid_we_n", 32'(we_n_s), 32'd1);
        chk("rst_mid_dq_oe", 32'(dq_oe_s), 32'd0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if_ready_s || mem_ready_s) rdy++;
        end
        chk("rst_mid_no_ready", rdy, 0);

        // Contention from reset, then continuous pressure on both ports.
        fexp[0] = 32'h1234_5678; fexp[1] = 32'hDEAD_BEEF;
        fexp[2] = 32'hDEAD_BEEF; fexp[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        if_addr = 32'h8; if_req = 1'b1;
        mem_we = 1'b0; mem_addr = 32'h10; mem_req = 1'b1;
        cyc = 0; nrd = 0; both = 0;
        while (nrd < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if_ready_s && mem_ready_s) both++;
            if (if_ready_s || mem_ready_s) begin
                got[nrd]  = mem_ready_s;
                gcyc[nrd] = cyc;
                gdat[nrd] = mem_ready_s ? mem_rdata_s : if_rdata_s;
                if (mem_ready_s) mem_addr = 32'h8;
                nrd++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("fair_count", nrd, 4);
        chk("fair_both", both, 0);
        for (int i = 0; i < nrd; i++) begin
            chk($sformatf("fair%0d_port", i), 32'(got[i]),
                (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("fair%0d_cycle", i), gcyc[i], 5 + 6 * i);
            chk($sformatf("fair%0d_data", i), gdat[i], fexp[i]);
        end

        // Random traffic against the word-level model.
        do_reset();
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            bd_write(1'b0, 18'(2 * w), ref_mem[w][15:0]);
            bd_write(1'b0, 18'(2 * w + 1), ref_mem[w][31:16]);
        end
        lg_m = 1'b0; exp_if_m = '0; exp_mem_m = '0;
        sel4 = 1'b0;
        rnd_test(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_mem_arbiter.md
Name: sram_mem_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM between the MIPS instruction-fetch port (IF, read-only) and the data-memory port (MEM, read/write).
- Splits every 32-bit word access into two sequenced 16-bit SRAM phases and arbitrates between the two requesters.
- Returns one-cycle ready pulses; the pipeline uses them to stall and advance.
- Sits inside the MIPS top level, between the pipeline memory stages and the SRAM_* board pins.

Parameters:
- ACC_CYCLES, 2, clock cycles per 16-bit SRAM phase (legal range 2..15).
- AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  synchronous active-high reset (SW[0] at top level)
- if_req  in  1  IF read request; held until if_ready
- if_addr  in  32  IF byte address
- if_rdata  out  32  IF read data; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse to IF
- mem_req  in  1  MEM request; held until mem_ready
- mem_we  in  1  1=write, 0=read
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  MEM write data
- mem_rdata  out  32  MEM read data; valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse to MEM
- busy  out  1  1 in any state other than IDLE
- sram_addr  out  AW  half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable; top level builds the SRAM_DQ tristate
- sram_dq_in  in  16  read data from pad
- sram_we_n, sram_oe_n, sram_ce_n  out  1 each  SRAM strobes, active-low
- sram_ub_n, sram_lb_n  out  1 each  byte masks; tied 0

Behaviour:
- Clock, reset and interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - FSM=IDLE, last_grant=IF.
  - if_ready=0, mem_ready=0, rdata regs=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0.
- Reset mid-transaction: aborts immediately. No ready pulse is issued. A partially written word (low half only) is left as is.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE, arbitration (sampled each cycle):
  - Only one req high: grant it.
  - Both high: grant the port not equal to last_grant. Alternation prevents IF starvation.
  - On a grant: latch port, we, addr[AW:2] and wdata; update last_grant; go to LO.
  - No req: stay in IDLE.
- LO / HI phases, ACC_CYCLES cycles each, counted by a phase counter reset on entry:
  - sram_addr = {word_addr, 1'b0} in LO, {word_addr, 1'b1} in HI.
  - sram_ce_n=0 for the whole phase.
  - Read: sram_oe_n=0. sram_dq_in is captured into rdata[15:0] (LO) or rdata[31:16] (HI) on the last cycle of the phase.
  - Write: sram_dq_oe=1 for the whole phase. sram_dq_out = wdata[15:0] (LO) or wdata[31:16] (HI). sram_we_n=0 on every phase cycle except the first, so the address is set up one cycle before the write strobe.
- DONE:
  - Strobes are idle.
  - The granted port's ready=1 for exactly one cycle, with rdata valid (reads). For writes rdata holds its last value.
  - Then go to IDLE.
- Latency: grant in IDLE at cycle 0 -> ready at cycle 2*ACC_CYCLES+1 (cycle 5 at the default).
- Requester rules:
  - Address and data must stay stable from req until ready.
  - The cycle after ready, the requester presents a new request or deasserts.
  - A req still high in IDLE is treated as a new transaction.
- Address bits: addr[1:0] and bits above AW are ignored. Only word accesses are supported.
- At most one ready is high in any cycle. The non-granted port sees ready=0 throughout.

Decomposition:
- Shared defines file mips_mem_defs.vh holds:
  - state encodings ST_IDLE/ST_LO/ST_HI/ST_DONE;
  - GRANT_IF=0, GRANT_MEM=1;
  - default ACC_CYCLES.
- One natural sub-module: sram_phase_counter.
  - Loadable down-counter.
  - Outputs phase_first and phase_last.
  - Reused for both phases.

Test Plan:
- Reset: hold rst=1 for 3 cycles during a LO phase -> FSM returns to IDLE, all strobes high, dq_oe=0, no ready pulse; busy=0 the cycle after rst.
- IF read: preload SRAM halves 0x0004=0xBEEF, 0x0005=0xDEAD; if_req with if_addr=0x8 -> if_ready exactly at cycle 5, if_rdata=0xDEADBEEF, sram_oe_n low only during LO/HI.
- MEM write then read: mem_we=1, addr=0x10, wdata=0x12345678 -> SRAM[0x8]=0x5678, SRAM[0x9]=0x1234, we_n low 1 cycle per phase, mem_ready at cycle 5; a following read returns 0x12345678.
- Simultaneous: if_req and mem_req both high from reset (last_grant=IF) -> MEM served first (ready at cycle 5), IF served next (if_ready at cycle 11), never both ready together.
- Fairness: mem_req held continuously with new addresses and if_req high -> grants alternate MEM, IF, MEM, IF.
- Parameter sweep: ACC_CYCLES=4 -> ready at cycle 9; we_n low 3 cycles per write phase.
